// File: rtl/cmem_pkg.sv
// rtl/cmem_pkg.sv - shared cmem geometry defaults and controller state encoding
package cmem_pkg;

   localparam int CMEM_ADDR_W = 6;
   localparam int CMEM_DATA_W = 16;
   localparam int CMEM_NTAPS  = 1 << CMEM_ADDR_W;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } cmem_state_t;

endpackage

// File: rtl/cmem_ctrl.sv
// rtl/cmem_ctrl.sv - cmem initiator: loads a coefficient set, streams it back to the FIR MAC
// Optional CMEM_CTRL_OUTREG_EN adds an output register stage on the coef_* stream.
module cmem_ctrl
   import cmem_pkg::*;
#(
   parameter int ADDR_W = CMEM_ADDR_W,
   parameter int DATA_W = CMEM_DATA_W,
   parameter int NTAPS  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              rd_start,
   output logic              rd_busy,
   output logic              coef_valid,
   output logic [DATA_W-1:0] coef_data,
   output logic [ADDR_W-1:0] coef_idx,
   output logic              coef_last,
   output logic              mem_cen,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d,
   input  logic [DATA_W-1:0] mem_q
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NTAPS - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

   cmem_state_t       state;
   cmem_state_t       state_nxt;
   logic              ready_en;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   ncoef;
   logic [ADDR_W:0]   rd_ptr;
   logic              accept;
   logic              set_done;
   logic              rd_go;
   logic              rd_issue;
   logic              seq_done;
   logic              s1_valid;
   logic              s1_last;
   logic [ADDR_W-1:0] s1_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rd_go) state_nxt = READ;
         READ:    if (seq_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A load beat always wins over a same-cycle rd_start; partial loads block reads.
   always_comb begin
      load_ready = ready_en && (state == IDLE);
      rd_busy    = (state == READ);
      accept     = load_valid && load_ready;
      set_done   = accept && (load_last || (wr_ptr == LAST_PTR));
      rd_go      = load_ready && rd_start && !accept &&
                   (ncoef != '0) && (wr_ptr == '0);
      rd_issue   = (state == READ) && (rd_ptr < ncoef);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         wr_ptr   <= '0;
         ncoef    <= '0;
         rd_ptr   <= '0;
         mem_cen  <= 1'b1;
         mem_wen  <= 1'b1;
         mem_a    <= '0;
         mem_d    <= '0;
      end else begin
         ready_en <= 1'b1;
         mem_cen  <= 1'b1;
         mem_wen  <= 1'b1;
         if (accept) begin
            mem_cen <= 1'b0;
            mem_wen <= 1'b0;
            mem_a   <= wr_ptr;
            mem_d   <= load_data;
            if (set_done) begin
               ncoef  <= {1'b0, wr_ptr} + CNT_ONE;
               wr_ptr <= '0;
            end else begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
         end else if (rd_go) begin
            mem_cen <= 1'b0;
            mem_a   <= '0;
            rd_ptr  <= CNT_ONE;
         end else if (rd_issue) begin
            mem_cen <= 1'b0;
            mem_a   <= rd_ptr[ADDR_W-1:0];
            rd_ptr  <= rd_ptr + CNT_ONE;
         end
      end
   end

   // A read edge is the only time cen is low with wen high; tag it one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= !mem_cen && mem_wen;
         s1_last  <= !mem_cen && mem_wen && ({1'b0, mem_a} == (ncoef - CNT_ONE));
         if (!mem_cen && mem_wen) s1_idx <= mem_a;
      end
   end

`ifdef CMEM_CTRL_OUTREG_EN
   logic              s2_valid;
   logic              s2_last;
   logic [ADDR_W-1:0] s2_idx;
   logic [DATA_W-1:0] s2_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_idx   <= '0;
         s2_data  <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         s2_idx   <= s1_idx;
         if (s1_valid) s2_data <= mem_q;
      end
   end

   assign coef_valid = s2_valid;
   assign coef_data  = s2_data;
   assign coef_idx   = s2_idx;
   assign coef_last  = s2_last;
   assign seq_done   = s2_last;
`else
   assign coef_valid = s1_valid;
   assign coef_data  = s1_valid ? mem_q : '0;
   assign coef_idx   = s1_idx;
   assign coef_last  = s1_last;
   assign seq_done   = s1_last;
`endif

endmodule

// File: tb/tb_cmem_ctrl.sv
// tb/tb_cmem_ctrl.sv - scoreboard bench for cmem_ctrl with a behavioural cmem alongside
module tb_cmem_ctrl;

`ifdef CMEM_CTRL_OUTREG_EN
   localparam int EXP_LAT = 3;
`else
   localparam int EXP_LAT = 2;
`endif

   typedef struct packed {
      logic [5:0]  idx;
      logic [15:0] data;
      logic        last;
   } coef_t;

   typedef struct packed {
      logic [5:0]  a;
      logic [15:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        rd_start = 1'b0;
   logic        rd_busy;
   logic        coef_valid;
   logic [15:0] coef_data;
   logic [5:0]  coef_idx;
   logic        coef_last;
   logic        mem_cen;
   logic        mem_wen;
   logic [5:0]  mem_a;
   logic [15:0] mem_d;
   logic [15:0] mem_q = '0;

   logic [15:0] cmem [0:63];
   logic [15:0] exp_mem [0:63];
   coef_t       cq [$];
   wr_t         wq [$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_rd = 0;
   int          wr_ptr_m = 0;
   int          ncoef_m = 0;

   cmem_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .rd_start   (rd_start),
      .rd_busy    (rd_busy),
      .coef_valid (coef_valid),
      .coef_data  (coef_data),
      .coef_idx   (coef_idx),
      .coef_last  (coef_last),
      .mem_cen    (mem_cen),
      .mem_wen    (mem_wen),
      .mem_a      (mem_a),
      .mem_d      (mem_d),
      .mem_q      (mem_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!mem_cen) begin
         if (!mem_wen) cmem[mem_a] <= mem_d;
         else          mem_q <= cmem[mem_a];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   always @(negedge clk) begin : mon
      coef_t ce;
      wr_t   we;
      if (rst_n && !mem_cen && mem_wen) n_rd++;
      if (rst_n && !mem_cen && !mem_wen) begin
         if (wq.size() == 0) chk("unexp_wr", 1, 0);
         else begin
            we = wq.pop_front();
            chk("wr_a", mem_a, we.a);
            chk("wr_d", mem_d, we.d);
         end
      end
      if (rst_n && coef_valid) begin
         if (cq.size() == 0) chk("unexp_coef", 1, 0);
         else begin
            ce = cq.pop_front();
            chk("coef_idx", coef_idx, ce.idx);
            chk("coef_data", coef_data, ce.data);
            chk("coef_last", coef_last, ce.last);
         end
      end
   end

   task automatic load_beat(input logic [15:0] d, input bit last, input bit with_start);
      @(negedge clk);
      chk("ready", load_ready, 1);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      rd_start   = with_start;
      wq.push_back('{a: 6'(wr_ptr_m), d: d});
      exp_mem[wr_ptr_m] = d;
      if (last || wr_ptr_m == 63) begin
         ncoef_m  = wr_ptr_m + 1;
         wr_ptr_m = 0;
      end else begin
         wr_ptr_m++;
      end
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
      rd_start   = 1'b0;
   endtask

   task automatic do_read(input bit pulse_mid);
      int rd0;
      int lat;
      int cyc;
      bit go;
      go  = (ncoef_m != 0) && (wr_ptr_m == 0);
      rd0 = n_rd;
      if (go)
         for (int i = 0; i < ncoef_m; i++)
            cq.push_back('{idx: 6'(i), data: exp_mem[i], last: (i == ncoef_m - 1)});
      @(negedge clk);
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      lat = 1;
      if (!go) begin
         repeat (6) begin
            chk("drop_busy", rd_busy, 0);
            @(negedge clk);
         end
         chk("drop_rd", n_rd - rd0, 0);
      end else begin
         while (!coef_valid && lat < 8) begin
            @(negedge clk);
            lat++;
         end
         chk("latency", lat, EXP_LAT);
         cyc = 0;
         while (!coef_last && cyc < 80) begin
            rd_start = pulse_mid && (cyc == 2);
            @(negedge clk);
            cyc++;
         end
         rd_start = 1'b0;
         chk("last_seen", coef_last, 1);
         @(negedge clk);
         chk("busy_drop", rd_busy, 0);
         chk("valid_drop", coef_valid, 0);
         chk("ready_back", load_ready, 1);
         chk("rd_count", n_rd - rd0, ncoef_m);
         repeat (4) @(negedge clk);
         chk("idle_busy", rd_busy, 0);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] set1 [0:3];
      int rd0;
      set1[0] = 16'd4; set1[1] = 16'd62; set1[2] = 16'd4001; set1[3] = 16'd7;

      repeat (2) @(negedge clk);
      chk("rst_ready", load_ready, 0);
      chk("rst_busy", rd_busy, 0);
      chk("rst_cvalid", coef_valid, 0);
      chk("rst_clast", coef_last, 0);
      chk("rst_cdata", coef_data, 0);
      chk("rst_cidx", coef_idx, 0);
      chk("rst_cen", mem_cen, 1);
      chk("rst_wen", mem_wen, 1);
      chk("rst_a", mem_a, 0);
      chk("rst_d", mem_d, 0);
      rst_n = 1'b1;
      #1 chk("ready_after_rel", load_ready, 0);

      for (int i = 0; i < 4; i++) load_beat(set1[i], i == 3, 1'b0);
      do_read(1'b0);

      for (int i = 0; i < 64; i++) load_beat(16'(i), 1'b0, 1'b0);
      chk("wrap_ncoef", ncoef_m, 64);
      do_read(1'b0);

      load_beat(16'h1111, 1'b0, 1'b0);
      load_beat(16'h2222, 1'b0, 1'b0);
      do_read(1'b0);
      load_beat(16'h3333, 1'b1, 1'b0);
      do_read(1'b0);

      rd0 = n_rd;
      load_beat(16'h0abc, 1'b1, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk("beat_wins_busy", rd_busy, 0);
      end
      chk("beat_wins_rd", n_rd - rd0, 0);
      do_read(1'b0);

      for (int i = 0; i < 5; i++) load_beat(16'h5000 + 16'(i), i == 4, 1'b0);
      do_read(1'b1);

      for (int i = 0; i < 8; i++) load_beat(16'h0100 + 16'(i), i == 7, 1'b0);
      for (int i = 0; i < 8; i++)
         cq.push_back('{idx: 6'(i), data: exp_mem[i], last: (i == 7)});
      @(negedge clk);
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", rd_busy, 1);
      #2;
      rst_n = 1'b0;
      cq.delete();
      ncoef_m  = 0;
      wr_ptr_m = 0;
      #1;
      chk("mid_rst_cen", mem_cen, 1);
      chk("mid_rst_cvalid", coef_valid, 0);
      chk("mid_rst_ready", load_ready, 0);
      chk("mid_rst_busy", rd_busy, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1 chk("rel_ready", load_ready, 0);
      do_read(1'b0);

      repeat (3) @(negedge clk);
      chk("wq_empty", wq.size(), 0);
      chk("cq_empty", cq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
